// File: rtl/ctrl_iter_pkg.sv
// Shared types and defaults for the iteration controller that drives the
// accumulation engine.
package ctrl_iter_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int unsigned GAP_CYC_DEF     = 1;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;
  localparam int unsigned GAP_W           = 8;

  function automatic logic is_busy(state_e s);
    return (s == LOAD) || (s == RUN) || (s == GAP);
  endfunction

endpackage

// File: rtl/ctrl_iter_cyc_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module ctrl_iter_cyc_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ctrl_iter_seq.sv
// Iteration controller for the accumulation engine: RUN until done, GAP, repeat.
// Optional per-iteration watchdog enabled by defining CTRL_ITER_TIMEOUT_EN.
module ctrl_iter_seq
  import ctrl_iter_pkg::*;
#(
  parameter int unsigned ITER_W      = 8,
  parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_enableEntireModule,
  input  logic [ITER_W-1:0] in_numIters,
  input  logic              in_continuousMode,
  input  logic              in_accumCalcDoneFlag,
  output logic              op_enableAccumCalc,
  output logic              op_allItersDoneFlag,
  output logic [ITER_W-1:0] op_iterIndex,
  output logic              op_busy,
  output logic              op_timeoutErr
);

  if ((GAP_CYC < 1) || (GAP_CYC > 255)) begin : g_bad_gap
    $error("ctrl_iter_seq: GAP_CYC must be in 1..255");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("ctrl_iter_seq: TIMEOUT_CYC must be at least 1");
  end

  state_e            state_q, state_d;
  logic [ITER_W-1:0] num_iters_q, num_iters_d;
  logic [ITER_W-1:0] iter_idx_q, iter_idx_d;
  logic              cont_q, cont_d;
  logic              timeout_err_q, timeout_err_d;
  logic              last_iter;
  logic              restart_ok;
  logic              gap_zero;
  logic              wd_zero;

  assign last_iter = (iter_idx_q == (num_iters_q - ITER_W'(1)));

  // GAP length: loaded with GAP_CYC-1 on entry, leaves GAP when it reads zero.
  ctrl_iter_cyc_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clock),
    .rst_n      (reset),
    .load_i     ((state_d == GAP) && (state_q != GAP)),
    .load_val_i (GAP_W'(GAP_CYC - 1)),
    .dec_i      (state_q == GAP),
    .zero_o     (gap_zero)
  );

`ifdef CTRL_ITER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  // Reloaded on every entry to RUN, so each iteration gets TIMEOUT_CYC cycles.
  ctrl_iter_cyc_timer #(.W(WD_W)) u_wd_timer (
    .clk        (clock),
    .rst_n      (reset),
    .load_i     ((state_d == RUN) && (state_q != RUN)),
    .load_val_i (WD_W'(TIMEOUT_CYC - 1)),
    .dec_i      (state_q == RUN),
    .zero_o     (wd_zero)
  );

  assign restart_ok = cont_q && !timeout_err_q;
`else
  assign wd_zero    = 1'b0;
  assign restart_ok = cont_q;
`endif

  always_comb begin
    state_d       = state_q;
    num_iters_d   = num_iters_q;
    iter_idx_d    = iter_idx_q;
    cont_d        = cont_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        if (in_enableEntireModule) state_d = LOAD;
      end
      LOAD: begin
        if (!in_enableEntireModule)   state_d = IDLE;
        else if (num_iters_q == '0)   state_d = DONE;
        else                          state_d = RUN;
      end
      RUN: begin
        if (!in_enableEntireModule) begin
          state_d = IDLE;
        end else if (in_accumCalcDoneFlag) begin
          if (last_iter) begin
            state_d = DONE;
          end else begin
            state_d    = GAP;
            iter_idx_d = iter_idx_q + ITER_W'(1);
          end
        end else if (wd_zero) begin
          state_d       = DONE;
          timeout_err_d = 1'b1;
        end
      end
      GAP: begin
        if (!in_enableEntireModule) state_d = IDLE;
        else if (gap_zero)          state_d = RUN;
      end
      DONE: begin
        if (!in_enableEntireModule) state_d = IDLE;
        else if (restart_ok)        state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase

    // Configuration is captured only on entry to LOAD; later input changes wait for the next run.
    if (state_d == LOAD) begin
      num_iters_d = in_numIters;
      cont_d      = in_continuousMode;
      iter_idx_d  = '0;
    end
    if (state_d == IDLE) begin
      iter_idx_d    = '0;
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      num_iters_q   <= '0;
      iter_idx_q    <= '0;
      cont_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_iters_q   <= num_iters_d;
      iter_idx_q    <= iter_idx_d;
      cont_q        <= cont_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign op_enableAccumCalc  = (state_q == RUN);
  assign op_allItersDoneFlag = (state_q == DONE);
  assign op_busy             = is_busy(state_q);
  assign op_iterIndex        = iter_idx_q;

`ifdef CTRL_ITER_TIMEOUT_EN
  assign op_timeoutErr = timeout_err_q;
`else
  assign op_timeoutErr = 1'b0;
`endif

endmodule

// File: doc/ctrl_iter_seq.md
Name: ctrl_iter_seq

Overview:
Parametrised successor to the iteration control counter. It drives the accumulation engine through a programmable number of iterations.
- Per iteration: hold the engine enable until the engine's done flag, then force an idle gap, then advance the iteration index.
- Adds a runtime iteration count, single-shot and continuous modes, and an iteration-index output.
- Sits between the top-level module enable and the accumulation-calculation block in the y-integration path.

Parameters:
ITER_W, 8, width of iteration count and index
GAP_CYC, 1, cycles op_enableAccumCalc is held low between iterations (legal range 1..255)
TIMEOUT_CYC, 1024, watchdog limit in cycles per iteration (used only with the optional feature)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_enableEntireModule  in  1  level; run while high, abort when low
in_numIters  in  ITER_W  iteration count, sampled on leaving IDLE
in_continuousMode  in  1  1 = restart automatically after completion
in_accumCalcDoneFlag  in  1  engine done; one sample ends the current iteration
op_enableAccumCalc  out  1  enable to the accumulation engine
op_allItersDoneFlag  out  1  all iterations complete
op_iterIndex  out  ITER_W  current iteration, 0-based
op_busy  out  1  high in LOAD, RUN and GAP
op_timeoutErr  out  1  watchdog fired (tied 0 without the optional feature)

Behaviour:
- Reset (reset=0): state IDLE, all outputs 0, internal counters 0. Reset is honoured in any state, including mid-run.
- Outputs are Moore outputs, registered or decoded directly from the state register; there is no combinational input-to-output path.
- States: IDLE, LOAD, RUN, GAP, DONE.
- IDLE -> LOAD: on the edge where in_enableEntireModule=1. in_numIters is latched into numIters_q at this edge.
- LOAD -> DONE: if numIters_q==0. No enable pulse is issued.
- LOAD -> RUN: otherwise. op_iterIndex=0.
- Latency: op_enableAccumCalc rises 2 cycles after in_enableEntireModule is first sampled high.
- RUN: op_enableAccumCalc=1. On a sampled in_accumCalcDoneFlag:
  - if op_iterIndex==numIters_q-1 -> DONE;
  - else -> GAP, with the index incremented on the same edge.
- GAP: op_enableAccumCalc=0 for exactly GAP_CYC cycles, then -> RUN.
- in_accumCalcDoneFlag is ignored in IDLE, LOAD, GAP and DONE.
- A done flag held high for several cycles in RUN counts once. The next iteration can only end after passing through GAP.
- DONE: op_allItersDoneFlag=1, op_enableAccumCalc=0, op_iterIndex holds the last index.
  - in_continuousMode=0: stay in DONE while enable is high; -> IDLE when enable is low.
  - in_continuousMode=1 and enable high: DONE lasts 1 cycle (done is a 1-cycle pulse), then -> LOAD, which re-samples in_numIters.
- Abort: in_enableEntireModule=0 in LOAD, RUN or GAP -> IDLE on the next edge. Outputs clear, done is not asserted, index is reset.
- Width: index arithmetic is modulo 2^ITER_W. numIters_q max is 2^ITER_W-1, so the index never wraps during a run.
- Changes to in_numIters or in_continuousMode after LOAD have no effect until the next LOAD.

Optional Feature:
Macro CTRL_ITER_TIMEOUT_EN.
- Defined:
  - A per-iteration watchdog counts cycles spent in RUN and clears on entry to RUN.
  - If the count reaches TIMEOUT_CYC without a done flag: -> DONE with op_timeoutErr=1 and op_allItersDoneFlag=1.
  - op_timeoutErr is sticky until IDLE or reset.
  - Continuous restart is suppressed while op_timeoutErr=1.
- Undefined: no watchdog logic; op_timeoutErr is constant 0.

Decomposition:
- Package ctrl_iter_pkg: state enum typedef (IDLE, LOAD, RUN, GAP, DONE) with fixed encodings 3'd0..3'd4; default constants for GAP_CYC and TIMEOUT_CYC.
- One sub-module, ctrl_iter_cyc_timer: loadable down-counter with a zero flag. It is instantiated for the GAP count and, under the macro, for the watchdog.

Test Plan:
1. Reset low 2 cycles, then enable=1, numIters=1; done pulsed 1 cycle at cycle 12 -> op_enableAccumCalc high cycles 4..12; op_allItersDoneFlag=1 from cycle 13 and held; index 0.
2. numIters=3, GAP_CYC=2; done after 5 cycles each iteration -> three enable windows separated by exactly 2 low cycles; index 0,1,2; done asserts after the 3rd window.
3. numIters=0, enable=1 -> no enable pulse; op_allItersDoneFlag=1 two cycles after enable.
4. continuousMode=1, numIters=2, change in_numIters to 1 during the run -> 1-cycle done pulse, reload; second run has exactly 1 iteration.
5. Drop enable, and separately assert reset low, mid-RUN at iteration 1 of 4 -> all outputs 0 (next edge / immediately), index 0, done never asserted.
6. With CTRL_ITER_TIMEOUT_EN and TIMEOUT_CYC=16, never assert done -> after 16 RUN cycles op_timeoutErr=1 and op_allItersDoneFlag=1; enable low -> both clear.
